// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver with show-ahead receive FIFO and one-cycle error pulses.
// Optional even-parity support is compiled in by defining UART_RX_PARITY_EN.
module uart_rx #(
    parameter int CLK_DIV    = 54,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun,
    output logic       busy
);
    // state  | meaning
    // IDLE   | waiting for a 1->0 edge on rx_s; tick counter held at 0
    // START  | confirm start bit at mid-bit (sample 7), else reject as glitch
    // DATA   | shift 8 data bits LSB first, one every 16 ticks
    // PARITY | sample even-parity bit (UART_RX_PARITY_EN builds only)
    // STOP   | sample stop bit, queue result for the push slot, back to IDLE

    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [15:0] TICK_TC = 16'(CLK_DIV - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t      state, state_nxt;
    logic        rx_meta, rx_s, rx_prev;
    logic [15:0] tick_cnt;
    logic [3:0]  smp_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        tick, mid_start, bit_end;
    logic        enter, shift_en, stop_en;
    logic        fin_pend, fin_stop;
    logic        good, do_pop, do_push, full, empty;
    logic [AW:0] wr_ptr, rd_ptr;
    logic [7:0]  mem [FIFO_DEPTH];
`ifdef UART_RX_PARITY_EN
    logic        par_en, par_bad;
`endif

    assign tick      = (state != S_IDLE) && (tick_cnt == TICK_TC);
    assign mid_start = tick && (smp_cnt == 4'd7);
    assign bit_end   = tick && (smp_cnt == 4'd15);
    assign busy      = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        enter     = 1'b0;
        shift_en  = 1'b0;
        stop_en   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_en    = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (rx_prev && !rx_s) begin
                    state_nxt = S_START;
                    enter     = 1'b1;
                end
            end
            S_START: begin
                if (mid_start) begin
                    state_nxt = rx_s ? S_IDLE : S_DATA;
                    enter     = 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = S_PARITY;
`else
                        state_nxt = S_STOP;
`endif
                        enter = 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    par_en    = 1'b1;
                    state_nxt = S_STOP;
                    enter     = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    stop_en   = 1'b1;
                    state_nxt = S_IDLE;
                    enter     = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                enter     = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            rx_prev  <= 1'b1;
            state    <= S_IDLE;
            tick_cnt <= '0;
            smp_cnt  <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            fin_pend <= 1'b0;
            fin_stop <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
            state   <= state_nxt;

            if (state == S_IDLE || state_nxt == S_IDLE || tick)
                tick_cnt <= '0;
            else
                tick_cnt <= tick_cnt + 16'd1;

            // sample counter wraps 15->0 between data bits on its own
            if (enter)
                smp_cnt <= '0;
            else if (tick)
                smp_cnt <= smp_cnt + 4'd1;

            if (enter)
                bit_cnt <= '0;
            else if (shift_en)
                bit_cnt <= bit_cnt + 3'd1;

            if (shift_en)
                shreg <= {rx_s, shreg[7:1]};

            fin_pend <= stop_en;
            if (stop_en)
                fin_stop <= rx_s;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            par_bad <= 1'b0;
        else if (par_en)
            par_bad <= ^{shreg, rx_s};
    end

    assign good = fin_pend && fin_stop && !par_bad;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            parity_err <= 1'b0;
        else
            parity_err <= fin_pend && fin_stop && par_bad;
    end
`else
    assign good       = fin_pend && fin_stop;
    assign parity_err = 1'b0;
`endif

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rx_valid = !empty;
    assign rx_data  = mem[rd_ptr[AW-1:0]];
    assign do_pop   = rx_valid && rx_ready;
    assign do_push  = good && (!full || do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            frame_err <= fin_pend && !fin_stop;
            overrun   <= good && full && !do_pop;
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= shreg;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLK_DIV=4 (64 clk per bit), FIFO_DEPTH=4.
// Define UART_RX_PARITY_EN on both bench and RTL to exercise the parity build.
module tb_uart_rx;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 676;
`else
    localparam int LAT = 612;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, parity_err, overrun, busy;

    int vecs = 0;
    int errs = 0;
    int cyc = 0;
    int start_cyc = 0;
    int fe_cnt = 0, pe_cnt = 0, ov_cnt = 0;
    int fe_cyc = 0, pe_cyc = 0, ov_cyc = 0;
    int busy_fall_cyc = 0, valid_rise_cyc = 0;
    logic busy_seen = 1'b0, prev_busy = 1'b0, prev_valid = 1'b0;

    uart_rx #(.CLK_DIV(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .frame_err(frame_err), .parity_err(parity_err),
        .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (frame_err)  begin fe_cnt++; fe_cyc = cyc; end
        if (parity_err) begin pe_cnt++; pe_cyc = cyc; end
        if (overrun)    begin ov_cnt++; ov_cyc = cyc; end
        if (busy) busy_seen = 1'b1;
        if (prev_busy && !busy) busy_fall_cyc = cyc;
        if (!prev_valid && rx_valid) valid_rise_cyc = cyc;
        prev_busy  = busy;
        prev_valid = rx_valid;
    end

    task automatic clear_mon();
        fe_cnt = 0; pe_cnt = 0; ov_cnt = 0; busy_seen = 1'b0;
    endtask

    task automatic send_bits(input logic [10:0] bits, input int nbits);
        @(negedge clk);
        start_cyc = cyc;
        for (int i = 0; i < nbits; i++) begin
            rx = bits[i];
            repeat (64) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
`ifdef UART_RX_PARITY_EN
        send_bits({stop, ^d, d, 1'b0}, 11);
`else
        send_bits({1'b0, stop, d, 1'b0}, 10);
`endif
    endtask

    task automatic pop_one();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        vecs++; if (rx_valid !== 1'b0)   begin errs++; $display("FAIL reset_valid got %b want 0", rx_valid); end
        vecs++; if (rx_data !== 8'h00)   begin errs++; $display("FAIL reset_data got %h want 00", rx_data); end
        vecs++; if (busy !== 1'b0)       begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
        vecs++; if (frame_err !== 1'b0)  begin errs++; $display("FAIL reset_ferr got %b want 0", frame_err); end
        vecs++; if (parity_err !== 1'b0) begin errs++; $display("FAIL reset_perr got %b want 0", parity_err); end
        vecs++; if (overrun !== 1'b0)    begin errs++; $display("FAIL reset_ovr got %b want 0", overrun); end
        reset = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_good_frame();
        clear_mon();
        send_frame(8'hA5, 1'b1);
        repeat (4) @(negedge clk);
        vecs++; if (rx_valid !== 1'b1) begin errs++; $display("FAIL good_valid got %b want 1", rx_valid); end
        vecs++; if (rx_data !== 8'hA5) begin errs++; $display("FAIL good_data got %h want a5", rx_data); end
        vecs++; if (valid_rise_cyc - start_cyc != LAT)
            begin errs++; $display("FAIL good_latency got %0d want %0d", valid_rise_cyc - start_cyc, LAT); end
        vecs++; if (valid_rise_cyc - busy_fall_cyc != 1)
            begin errs++; $display("FAIL good_push_slot got %0d want 1", valid_rise_cyc - busy_fall_cyc); end
        vecs++; if (fe_cnt + pe_cnt + ov_cnt != 0)
            begin errs++; $display("FAIL good_no_err got %0d pulses want 0", fe_cnt + pe_cnt + ov_cnt); end
        pop_one();
        vecs++; if (rx_valid !== 1'b0) begin errs++; $display("FAIL good_pop got %b want 0", rx_valid); end
    endtask

    task automatic test_glitch();
        clear_mon();
        @(negedge clk);
        start_cyc = cyc;
        rx = 1'b0;
        repeat (12) @(negedge clk);
        rx = 1'b1;
        repeat (60) @(negedge clk);
        vecs++; if (busy_seen !== 1'b1) begin errs++; $display("FAIL glitch_busy_seen got %b want 1", busy_seen); end
        vecs++; if (busy !== 1'b0)      begin errs++; $display("FAIL glitch_idle got %b want 0", busy); end
        vecs++; if (busy_fall_cyc - start_cyc != 35)
            begin errs++; $display("FAIL glitch_reject_time got %0d want 35", busy_fall_cyc - start_cyc); end
        vecs++; if (rx_valid !== 1'b0)  begin errs++; $display("FAIL glitch_valid got %b want 0", rx_valid); end
        vecs++; if (fe_cnt + pe_cnt + ov_cnt != 0)
            begin errs++; $display("FAIL glitch_no_err got %0d pulses want 0", fe_cnt + pe_cnt + ov_cnt); end
    endtask

    task automatic test_frame_err();
        clear_mon();
        send_frame(8'h3C, 1'b0);
        repeat (4) @(negedge clk);
        vecs++; if (fe_cnt != 1) begin errs++; $display("FAIL ferr_pulses got %0d want 1", fe_cnt); end
        vecs++; if (fe_cyc - start_cyc != LAT)
            begin errs++; $display("FAIL ferr_slot got %0d want %0d", fe_cyc - start_cyc, LAT); end
        vecs++; if (rx_valid !== 1'b0) begin errs++; $display("FAIL ferr_no_push got %b want 0", rx_valid); end
        send_frame(8'h55, 1'b1);
        repeat (4) @(negedge clk);
        vecs++; if (rx_valid !== 1'b1) begin errs++; $display("FAIL ferr_next_valid got %b want 1", rx_valid); end
        vecs++; if (rx_data !== 8'h55) begin errs++; $display("FAIL ferr_next_data got %h want 55", rx_data); end
        vecs++; if (fe_cnt != 1) begin errs++; $display("FAIL ferr_next_clean got %0d want 1", fe_cnt); end
        pop_one();
    endtask

    task automatic test_overrun();
        clear_mon();
        rx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        repeat (4) @(negedge clk);
        vecs++; if (ov_cnt != 1) begin errs++; $display("FAIL ovr_pulses got %0d want 1", ov_cnt); end
        vecs++; if (ov_cyc - start_cyc != LAT)
            begin errs++; $display("FAIL ovr_slot got %0d want %0d", ov_cyc - start_cyc, LAT); end
        for (int i = 0; i < 4; i++) begin
            vecs++; if (rx_valid !== 1'b1) begin errs++; $display("FAIL drain_valid[%0d] got %b want 1", i, rx_valid); end
            vecs++; if (rx_data !== 8'(i + 1))
                begin errs++; $display("FAIL drain_data[%0d] got %h want %h", i, rx_data, 8'(i + 1)); end
            pop_one();
        end
        vecs++; if (rx_valid !== 1'b0) begin errs++; $display("FAIL drain_empty got %b want 0", rx_valid); end
    endtask

    task automatic test_parity();
        clear_mon();
`ifdef UART_RX_PARITY_EN
        send_bits({1'b1, 1'b0, 8'h07, 1'b0}, 11);
        repeat (4) @(negedge clk);
        vecs++; if (pe_cnt != 1) begin errs++; $display("FAIL par_bad_pulses got %0d want 1", pe_cnt); end
        vecs++; if (pe_cyc - start_cyc != LAT)
            begin errs++; $display("FAIL par_bad_slot got %0d want %0d", pe_cyc - start_cyc, LAT); end
        vecs++; if (rx_valid !== 1'b0) begin errs++; $display("FAIL par_bad_no_push got %b want 0", rx_valid); end
        send_bits({1'b1, 1'b1, 8'h07, 1'b0}, 11);
        repeat (4) @(negedge clk);
        vecs++; if (rx_valid !== 1'b1) begin errs++; $display("FAIL par_ok_valid got %b want 1", rx_valid); end
        vecs++; if (rx_data !== 8'h07) begin errs++; $display("FAIL par_ok_data got %h want 07", rx_data); end
        vecs++; if (pe_cnt != 1) begin errs++; $display("FAIL par_ok_clean got %0d want 1", pe_cnt); end
        pop_one();
`else
        send_frame(8'h07, 1'b1);
        repeat (4) @(negedge clk);
        vecs++; if (pe_cnt != 0) begin errs++; $display("FAIL par_off_pulses got %0d want 0", pe_cnt); end
        vecs++; if (rx_data !== 8'h07) begin errs++; $display("FAIL par_off_data got %h want 07", rx_data); end
        pop_one();
`endif
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        d = 8'h81;
        clear_mon();
        @(negedge clk);
        rx = 1'b0;
        repeat (64) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            repeat (64) @(negedge clk);
        end
        rx = d[4];
        repeat (32) @(negedge clk);
        vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL mid_busy_before got %b want 1", busy); end
        reset = 1'b0;
        #1;
        vecs++; if (busy !== 1'b0)     begin errs++; $display("FAIL mid_busy_reset got %b want 0", busy); end
        vecs++; if (rx_valid !== 1'b0) begin errs++; $display("FAIL mid_valid_reset got %b want 0", rx_valid); end
        rx = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL mid_idle_after got %b want 0", busy); end
        send_frame(8'h81, 1'b1);
        repeat (4) @(negedge clk);
        vecs++; if (rx_valid !== 1'b1) begin errs++; $display("FAIL mid_next_valid got %b want 1", rx_valid); end
        vecs++; if (rx_data !== 8'h81) begin errs++; $display("FAIL mid_next_data got %h want 81", rx_data); end
        vecs++; if (valid_rise_cyc - start_cyc != LAT)
            begin errs++; $display("FAIL mid_next_latency got %0d want %0d", valid_rise_cyc - start_cyc, LAT); end
        pop_one();
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_parity();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
